// File: rtl/ws2812_decoder.sv
// ws2812_decoder: decodes a WS2812 single-wire serial stream into 24-bit colour words.
//
// A pulse on DIN is classified by its high time: glitch (< T_HMIN), bit 0
// (< T_TH), bit 1 (<= T_HMAX) or overlong (> T_HMAX). A low run of TR cycles
// is a frame reset gap. After reset or any protocol error the decoder waits
// in SYNC for a full gap before it decodes again.
//
// Ports:
//   CLK          system clock (50 MHz)
//   RST          synchronous active-high reset
//   DIN          asynchronous serial data line
//   color        last decoded word, first received bit in color[23]
//   color_valid  one-cycle strobe, color updated in the same cycle
//   pixel_count  words since the last frame_end, saturating at 255
//   frame_end    one-cycle strobe on a reset gap that follows activity
//   err          one-cycle strobe on a protocol violation
module ws2812_decoder #(
    parameter int unsigned T_TH   = 31,
    parameter int unsigned T_HMIN = 8,
    parameter int unsigned T_HMAX = 60,
    parameter int unsigned TR     = 2560
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DIN,
    output logic [23:0] color,
    output logic        color_valid,
    output logic [7:0]  pixel_count,
    output logic        frame_end,
    output logic        err
);

    localparam logic [6:0]  HTh   = 7'(T_TH);
    localparam logic [6:0]  HMin  = 7'(T_HMIN);
    localparam logic [6:0]  HMax  = 7'(T_HMAX);
    localparam logic [11:0] TrCnt = 12'(TR);
    localparam logic [11:0] TrM1  = 12'(TR - 1);

    typedef enum logic [1:0] {StSync, StLow, StHigh} state_e;

    state_e state_q, state_d;

    // din_d is din_s one cycle late (edge detection), not a next-state value.
    logic din_meta, din_s, din_d;

    logic [11:0] low_cnt_q,  low_cnt_d;
    logic [6:0]  high_cnt_q, high_cnt_d;
    logic [4:0]  bit_cnt_q,  bit_cnt_d;
    logic [22:0] shift_q,    shift_d;

    logic [23:0] color_d;
    logic        color_valid_d;
    logic [7:0]  pixel_count_d;
    logic        frame_end_d;
    logic        err_d;

    logic        bit_val;
    logic [23:0] word;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
            din_d    <= 1'b0;
        end else begin
            din_meta <= DIN;
            din_s    <= din_meta;
            din_d    <= din_s;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StSync: begin
                if (!din_s && low_cnt_q == TrM1) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (din_s && !din_d) begin
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (din_s) begin
                    // One more high cycle would exceed the legal maximum.
                    if (high_cnt_q >= HMax) begin
                        state_d = StSync;
                    end
                end else if (high_cnt_q < HMin) begin
                    state_d = StSync;
                end else begin
                    state_d = StLow;
                end
            end
            default: state_d = StSync;
        endcase
    end

    assign bit_val = (high_cnt_q >= HTh);
    assign word    = {shift_q, bit_val};

    // Datapath and strobe outputs.
    always_comb begin
        low_cnt_d     = low_cnt_q;
        high_cnt_d    = high_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        color_d       = color;
        color_valid_d = 1'b0;
        frame_end_d   = 1'b0;
        err_d         = 1'b0;
        // pixel_count drops to zero the cycle after the frame_end strobe.
        pixel_count_d = frame_end ? 8'd0 : pixel_count;

        case (state_q)
            StSync: begin
                high_cnt_d = 7'd0;
                bit_cnt_d  = 5'd0;
                if (din_s) begin
                    low_cnt_d = 12'd0;
                end else if (low_cnt_q == TrM1) begin
                    // Enter LOW already saturated so this gap cannot raise frame_end.
                    low_cnt_d = TrCnt;
                end else if (low_cnt_q != TrCnt) begin
                    low_cnt_d = low_cnt_q + 12'd1;
                end
            end
            StLow: begin
                if (din_s && !din_d) begin
                    low_cnt_d  = 12'd0;
                    high_cnt_d = 7'd1;
                end else if (!din_s) begin
                    if (low_cnt_q != TrCnt) begin
                        low_cnt_d = low_cnt_q + 12'd1;
                    end
                    if (low_cnt_q == TrM1 && (pixel_count != 8'd0 || bit_cnt_q != 5'd0)) begin
                        frame_end_d = 1'b1;
                        err_d       = (bit_cnt_q != 5'd0);
                        bit_cnt_d   = 5'd0;
                    end
                end
            end
            StHigh: begin
                if (din_s) begin
                    if (high_cnt_q != 7'h7f) begin
                        high_cnt_d = high_cnt_q + 7'd1;
                    end
                    if (high_cnt_q >= HMax) begin
                        err_d     = 1'b1;
                        bit_cnt_d = 5'd0;
                    end
                end else if (high_cnt_q < HMin) begin
                    err_d     = 1'b1;
                    bit_cnt_d = 5'd0;
                end else if (bit_cnt_q == 5'd23) begin
                    color_d       = word;
                    color_valid_d = 1'b1;
                    bit_cnt_d     = 5'd0;
                    if (pixel_count != 8'hff) begin
                        pixel_count_d = pixel_count + 8'd1;
                    end
                end else begin
                    shift_d   = word[22:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            default: begin
                low_cnt_d  = 12'd0;
                high_cnt_d = 7'd0;
                bit_cnt_d  = 5'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            low_cnt_q   <= 12'd0;
            high_cnt_q  <= 7'd0;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 23'd0;
            color       <= 24'd0;
            color_valid <= 1'b0;
            pixel_count <= 8'd0;
            frame_end   <= 1'b0;
            err         <= 1'b0;
        end else begin
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            color       <= color_d;
            color_valid <= color_valid_d;
            pixel_count <= pixel_count_d;
            frame_end   <= frame_end_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_ws2812_decoder.sv
// tb_ws2812_decoder: directed self-checking bench for ws2812_decoder.
// DIN is driven on the falling clock edge; outputs are sampled on the falling edge.
module tb_ws2812_decoder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DIN;
    logic [23:0] color;
    logic        color_valid;
    logic [7:0]  pixel_count;
    logic        frame_end;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    int cyc = 0;
    int cv_cnt = 0;
    int err_cnt = 0;
    int fe_cnt = 0;
    int cv_cyc = 0;
    int err_cyc = 0;
    int fe_cyc = 0;
    int fall_cyc = 0;
    logic [23:0] last_color = 24'd0;

    ws2812_decoder dut (
        .CLK         (CLK),
        .RST         (RST),
        .DIN         (DIN),
        .color       (color),
        .color_valid (color_valid),
        .pixel_count (pixel_count),
        .frame_end   (frame_end),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe monitor.
    always @(negedge CLK) begin
        if (color_valid === 1'b1) begin
            cv_cnt     = cv_cnt + 1;
            cv_cyc     = cyc;
            last_color = color;
        end
        if (err === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (frame_end === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        DIN = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(input int h, input int l);
        DIN = 1'b1;
        repeat (h) @(negedge CLK);
        DIN = 1'b0;
        fall_cyc = cyc;
        repeat (l) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits,
                             input int h1, input int l1, input int h0, input int l0);
        for (int i = 23; i > 23 - nbits; i--) begin
            if (w[i]) pulse(h1, l1);
            else      pulse(h0, l0);
        end
    endtask

    // Nominal and compact encodings.
    task automatic send_slow(input logic [23:0] w);
        send_bits(w, 24, 41, 23, 20, 43);
    endtask

    task automatic send_fast(input logic [23:0] w, input int nbits);
        send_bits(w, nbits, 31, 2, 8, 2);
    endtask

    initial begin
        int e0;
        int f0;
        int c0;
        int k;

        RST = 1'b1;
        DIN = 1'b1;
        repeat (4) @(negedge CLK);
        check("rst_color", 32'(color), 32'h0);
        check("rst_cv", 32'(color_valid), 32'h0);
        check("rst_pc", 32'(pixel_count), 32'h0);
        check("rst_fe", 32'(frame_end), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        RST = 1'b0;

        // Sync then one word at nominal timing.
        idle(2600);
        send_slow(24'hFF0000);
        check("w1_cv_cnt", 32'(cv_cnt), 32'd1);
        check("w1_color", 32'(color), 32'hFF0000);
        check("w1_last", 32'(last_color), 32'hFF0000);
        check("w1_pc", 32'(pixel_count), 32'd1);
        check("w1_err", 32'(err_cnt), 32'd0);
        check("w1_fe", 32'(fe_cnt), 32'd0);
        check("w1_latency", 32'(cv_cyc - fall_cyc), 32'd3);

        // Two words then a gap.
        send_slow(24'h123456);
        check("w2_last", 32'(last_color), 32'h123456);
        check("w2_pc", 32'(pixel_count), 32'd2);
        send_slow(24'hABCDEF);
        check("w3_last", 32'(last_color), 32'hABCDEF);
        check("w3_pc", 32'(pixel_count), 32'd3);
        check("w3_cv_cnt", 32'(cv_cnt), 32'd3);
        idle(2700);
        check("gap_fe", 32'(fe_cnt), 32'd1);
        check("gap_err", 32'(err_cnt), 32'd0);
        check("gap_pc", 32'(pixel_count), 32'd0);
        check("gap_cv_cnt", 32'(cv_cnt), 32'd3);
        check("gap_hold", 32'(color), 32'hABCDEF);

        // Short glitch mid-word, then ungapped word ignored, then gapped word decodes.
        send_fast(24'h0F0F0F, 5);
        pulse(4, 40);
        send_fast(24'h0F0F0F, 19);
        check("gl_err", 32'(err_cnt), 32'd1);
        send_fast(24'h0F0F0F, 24);
        idle(5);
        check("gl_cv_cnt", 32'(cv_cnt), 32'd3);
        check("gl_hold", 32'(color), 32'hABCDEF);
        idle(2600);
        check("gl_no_fe", 32'(fe_cnt), 32'd1);
        send_fast(24'h0F0F0F, 24);
        idle(5);
        check("gl_resync_color", 32'(color), 32'h0F0F0F);
        check("gl_resync_cv", 32'(cv_cnt), 32'd4);
        check("gl_resync_pc", 32'(pixel_count), 32'd1);

        // Overlong high.
        idle(2600);
        check("ol_fe", 32'(fe_cnt), 32'd2);
        check("ol_pc0", 32'(pixel_count), 32'd0);
        e0 = err_cnt;
        DIN = 1'b1;
        k = cyc;
        repeat (100) @(negedge CLK);
        idle(50);
        check("ol_err", 32'(err_cnt), 32'(e0 + 1));
        check("ol_err_time", 32'(err_cyc - k), 32'd63);
        send_fast(24'h777777, 24);
        idle(5);
        check("ol_ignored", 32'(cv_cnt), 32'd4);
        check("ol_err_once", 32'(err_cnt), 32'(e0 + 1));

        // Partial word at a gap.
        idle(2600);
        e0 = err_cnt;
        f0 = fe_cnt;
        c0 = cv_cnt;
        send_fast(24'h3C3C3C, 10);
        idle(2600);
        check("pw_err", 32'(err_cnt), 32'(e0 + 1));
        check("pw_fe", 32'(fe_cnt), 32'(f0 + 1));
        check("pw_same_cycle", 32'(err_cyc), 32'(fe_cyc));
        check("pw_no_cv", 32'(cv_cnt), 32'(c0));
        check("pw_hold", 32'(color), 32'h0F0F0F);

        // Threshold sweep.
        send_bits(24'hA5C3E1, 24, 31, 40, 30, 40);
        idle(5);
        check("th_30_31", 32'(color), 32'hA5C3E1);
        check("th_pc1", 32'(pixel_count), 32'd1);
        send_bits(24'h5A3C1E, 24, 41, 23, 8, 40);
        idle(5);
        check("th_8", 32'(color), 32'h5A3C1E);
        check("th_pc2", 32'(pixel_count), 32'd2);
        e0 = err_cnt;
        c0 = cv_cnt;
        pulse(7, 40);
        check("th_7_err", 32'(err_cnt), 32'(e0 + 1));
        check("th_7_no_cv", 32'(cv_cnt), 32'(c0));

        // Reset mid-word.
        idle(2600);
        send_fast(24'hFFFFFF, 12);
        DIN = 1'b1;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("mr_color", 32'(color), 32'h0);
        check("mr_pc", 32'(pixel_count), 32'h0);
        check("mr_cv", 32'(color_valid), 32'h0);
        check("mr_err", 32'(err), 32'h0);
        check("mr_fe", 32'(frame_end), 32'h0);
        RST = 1'b0;
        idle(5);
        c0 = cv_cnt;
        send_fast(24'h00FF00, 24);
        idle(5);
        check("mr_ignored", 32'(cv_cnt), 32'(c0));
        check("mr_color_zero", 32'(color), 32'h0);
        idle(2600);
        send_fast(24'h00FF00, 24);
        idle(5);
        check("mr_resync_color", 32'(color), 32'h00FF00);
        check("mr_resync_pc", 32'(pixel_count), 32'd1);

        // pixel_count saturation with minimal-length zero bits.
        c0 = cv_cnt;
        for (int n = 0; n < 254; n++) send_bits(24'h000000, 24, 31, 1, 8, 1);
        idle(5);
        check("sat_pc255", 32'(pixel_count), 32'd255);
        check("sat_color", 32'(color), 32'h0);
        for (int n = 0; n < 2; n++) send_bits(24'h000000, 24, 31, 1, 8, 1);
        idle(5);
        check("sat_hold", 32'(pixel_count), 32'd255);
        check("sat_cv_cnt", 32'(cv_cnt), 32'(c0 + 256));
        f0 = fe_cnt;
        idle(2600);
        check("sat_fe", 32'(fe_cnt), 32'(f0 + 1));
        check("sat_pc_clr", 32'(pixel_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ws2812_decoder.md
WS2812_DECODER -- requirements
Module: ws2812_decoder

Interface
REQ-001 Parameter T_TH, default 31, meaning: minimum high time in CLK cycles decoded as bit 1; shorter valid pulses decode as bit 0.
REQ-002 Parameter T_HMIN, default 8, meaning: minimum legal high time in cycles; shorter pulses are glitches.
REQ-003 Parameter T_HMAX, default 60, meaning: maximum legal high time in cycles.
REQ-004 Parameter TR, default 2560, meaning: continuous low cycles that constitute a frame reset gap (51.2 us at 50 MHz).
REQ-005 CLK  input  1  system clock, 50 MHz.
REQ-006 RST  input  1  reset; synchronous and active-high.
REQ-007 DIN  input  1  asynchronous WS2812 serial data line.
REQ-008 color  output  24  last decoded word; first received bit in color[23].
REQ-009 color_valid  output  1  one-cycle strobe; color is updated in the same cycle.
REQ-010 pixel_count  output  8  words decoded since the last frame_end; saturates at 255.
REQ-011 frame_end  output  1  one-cycle strobe on reset-gap detection after activity.
REQ-012 err  output  1  one-cycle strobe on protocol violation.

Function
REQ-013 DIN SHALL pass through a 2-flop synchronizer; din_s is the synchronizer output; din_d is din_s delayed one cycle.
REQ-014 The FSM SHALL have states SYNC, LOW, and HIGH.
REQ-015 SYNC: count consecutive din_s==0 cycles; any din_s==1 clears the count; count reaching TR -> LOW with bit_cnt=0.
REQ-016 LOW: low counter (12-bit, saturating at TR) increments each low cycle.
REQ-017 In LOW, rising edge (din_s=1, din_d=0) -> HIGH, clears the low counter, and loads high_cnt=1.
REQ-018 HIGH: high_cnt (7-bit, saturating) increments each cycle din_s==1.
REQ-019 In HIGH, high_cnt exceeding T_HMAX -> err pulse, discard the partial word, bit_cnt=0, -> SYNC.
REQ-020 In HIGH, falling edge with high_cnt < T_HMIN -> err pulse, discard the partial word, -> SYNC.
REQ-021 In HIGH, falling edge with T_HMIN <= high_cnt < T_TH -> shift in 0, -> LOW.
REQ-022 In HIGH, falling edge with T_TH <= high_cnt <= T_HMAX -> shift in 1, -> LOW.
REQ-023 Bits SHALL shift MSB first; bit_cnt counts 0..23.
REQ-024 On the 24th bit, the full word SHALL be copied to color, color_valid pulsed, pixel_count incremented (saturating), and bit_cnt set to 0.
REQ-025 Latency: color_valid SHALL be high on the CLK edge 2 edges after the first edge that samples the final DIN fall low.
REQ-026 In LOW, the low counter reaching TR with (pixel_count!=0 or bit_cnt!=0) SHALL pulse frame_end once; pixel_count clears the cycle after the pulse.
REQ-027 If bit_cnt!=0 at the gap, err SHALL pulse in the same cycle as frame_end, and the partial word is discarded without a color_valid pulse.
REQ-028 Further low cycles after a gap SHALL produce no additional frame_end.
REQ-029 Word completion and pixel_count saturation: pixel_count SHALL stay at 255 while color_valid still pulses.
REQ-030 color SHALL hold its value between color_valid strobes.
REQ-031 In SYNC, no bits are decoded and no color_valid is produced.

Reset
REQ-032 RST high at a CLK edge SHALL force: state SYNC, all counters 0, color=0, color_valid=0, pixel_count=0, frame_end=0, err=0, and synchronizer flops=0.
REQ-033 RST SHALL take priority over every simultaneous event, including RST asserted mid-word; after release a full TR low gap is required before decoding.

Verification
REQ-034 Reset; DIN low 2560+ cycles; send 0xFF0000 (1 = 41H/23L, 0 = 20H/43L) -> one color_valid, color=0xFF0000, pixel_count=1, err never asserted.
REQ-035 After sync, send 0x123456 then 0xABCDEF, then 2600 low -> two color_valid strobes with those values; one frame_end; pixel_count returns to 0.
REQ-036 After sync, a 4-cycle high glitch mid-word -> err; no color_valid; a following word without a TR gap is ignored; the same word after a TR gap decodes.
REQ-037 After sync, DIN held high 100 cycles -> exactly one err, when high_cnt reaches 61; state SYNC; no color_valid.
REQ-038 After sync, 10 bits then 2600 low -> err and frame_end in the same cycle; no color_valid; color unchanged.
REQ-039 Threshold sweep: high widths 30 and 31 cycles with 40L -> decode as 0 and 1 respectively; widths 7 -> err and 8 -> decodes as 0.
